// File: rtl/edge_event_pkg.sv
// Shared types and defaults for the debounced edge event counter.
package edge_event_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_CHK_LO = 2'd3
    } state_e;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;
    localparam int STAB_W            = 8;

endpackage

// File: rtl/edge_event_counter_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/edge_event_counter.sv
// Debounces an asynchronous level, pulses on accepted rising changes and
// counts those pulses into a saturating counter.
module edge_event_counter
    import edge_event_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic             filt,
    output logic             rise,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [STAB_W-1:0] STAB_LIM = STAB_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic              sync2;
    state_e            state_q,  state_d;
    logic [STAB_W-1:0] stab_q,   stab_d;
    logic              filt_q,   filt_d;
    logic              rise_q,   rise_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              sat_q,    sat_d;
    logic [CNT_W-1:0]  count_inc;

    bit_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (sync2)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            stab_q  <= '0;
            filt_q  <= 1'b0;
            rise_q  <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            filt_q  <= filt_d;
            rise_q  <= rise_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state logic; a limit of one skips the check states entirely
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        unique case (state_q)
            ST_LOW: begin
                if (sync2) begin
                    if (STAB_LIM == 8'd1) begin
                        state_d = ST_HIGH;
                        stab_d  = '0;
                    end else begin
                        state_d = ST_CHK_HI;
                        stab_d  = 8'd1;
                    end
                end
            end
            ST_CHK_HI: begin
                if (!sync2) begin
                    state_d = ST_LOW;
                    stab_d  = '0;
                end else if (stab_q + 8'd1 == STAB_LIM) begin
                    state_d = ST_HIGH;
                    stab_d  = '0;
                end else begin
                    stab_d  = stab_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (!sync2) begin
                    if (STAB_LIM == 8'd1) begin
                        state_d = ST_LOW;
                        stab_d  = '0;
                    end else begin
                        state_d = ST_CHK_LO;
                        stab_d  = 8'd1;
                    end
                end
            end
            ST_CHK_LO: begin
                if (sync2) begin
                    state_d = ST_HIGH;
                    stab_d  = '0;
                end else if (stab_q + 8'd1 == STAB_LIM) begin
                    state_d = ST_LOW;
                    stab_d  = '0;
                end else begin
                    stab_d  = stab_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_LOW;
                stab_d  = '0;
            end
        endcase
    end

    // Output logic, decoded from the next state so filt/rise are registered
    always_comb begin
        filt_d = (state_d == ST_HIGH) || (state_d == ST_CHK_LO);
        rise_d = filt_d && !filt_q;
    end

    // Counter consumes the registered rise pulse; clear wins over an increment
    assign count_inc = count_q + 1'b1;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (rise_q && en && !sat_q) begin
            count_d = count_inc;
            if (count_inc == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    assign filt  = filt_q;
    assign rise  = rise_q;
    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_edge_event_counter.sv
// Directed bench: debounce latency, glitch rejection, counting, saturation,
// clear/enable interaction and mid-operation reset.
module tb_edge_event_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       en;
    logic       clr;
    logic       filt,  rise,  sat;
    logic [3:0] count;
    logic       filt1, rise1, sat1;
    logic [7:0] count1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    edge_event_counter #(.STABLE_CYCLES(4), .CNT_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .en    (en),
        .clr   (clr),
        .filt  (filt),
        .rise  (rise),
        .count (count),
        .sat   (sat)
    );

    edge_event_counter #(.STABLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .en    (en),
        .clr   (clr),
        .filt  (filt1),
        .rise  (rise1),
        .count (count1),
        .sat   (sat1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a fresh rising event and stop in the cycle where rise is high
    task automatic pulse_to_rise();
        din = 1'b0;
        step(7);
        din = 1'b1;
        step(6);
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b1;
        en    = 1'b1;
        clr   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_filt",  32'(filt),  32'd0);
            check("rst_rise",  32'(rise),  32'd0);
            check("rst_count", 32'(count), 32'd0);
            check("rst_sat",   32'(sat),   32'd0);
            check("rst_filt1", 32'(filt1), 32'd0);
        end

        din   = 1'b0;
        rst_n = 1'b1;
        step(4);
        check("idle_filt", 32'(filt), 32'd0);

        // Clean rising edge: filt rises after the 6th edge seeing din=1
        din = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            check("clean_filt",  32'(filt),  32'(i >= 6));
            check("clean_rise",  32'(rise),  32'(i == 6));
            check("clean_filt1", 32'(filt1), 32'(i >= 3));
        end
        check("clean_count_pre", 32'(count), 32'd0);
        step(1);
        check("clean_rise_off", 32'(rise),   32'd0);
        check("clean_count",    32'(count),  32'd1);
        check("clean_count1",   32'(count1), 32'd1);

        // Clean falling edge: no rise pulse
        din = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            check("fall_filt", 32'(filt), 32'(i < 6));
            check("fall_rise", 32'(rise), 32'd0);
        end

        // Three-cycle high glitch is rejected
        din = 1'b1;
        step(3);
        din = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("gl_hi_filt", 32'(filt), 32'd0);
            check("gl_hi_rise", 32'(rise), 32'd0);
        end
        check("gl_hi_count", 32'(count), 32'd1);

        din = 1'b1;
        step(7);
        check("high_filt",  32'(filt),  32'd1);
        check("high_count", 32'(count), 32'd2);

        // Two-cycle low glitch while high is rejected
        din = 1'b0;
        step(2);
        din = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("gl_lo_filt", 32'(filt), 32'd1);
            check("gl_lo_rise", 32'(rise), 32'd0);
        end
        check("gl_lo_count", 32'(count), 32'd2);

        for (int p = 0; p < 3; p++) begin
            pulse_to_rise();
            step(1);
        end
        check("pre_coll_count", 32'(count), 32'd5);

        // Clear in the rise cycle discards that event
        pulse_to_rise();
        check("coll_rise", 32'(rise),  32'd1);
        check("coll_cnt5", 32'(count), 32'd5);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("coll_count", 32'(count), 32'd0);
        check("coll_filt",  32'(filt),  32'd1);

        // Enable low during the pulse: pulse seen, not counted
        pulse_to_rise();
        check("en0_rise", 32'(rise), 32'd1);
        en = 1'b0;
        step(1);
        en = 1'b1;
        check("en0_count", 32'(count), 32'd0);

        // Saturation at 15 with no wrap
        for (int p = 1; p <= 16; p++) begin
            pulse_to_rise();
            step(1);
            check("sat_count", 32'(count), 32'((p > 15) ? 15 : p));
            check("sat_flag",  32'(sat),   32'(p >= 15));
        end
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_sat",   32'(sat),   32'd0);
        check("clr_filt",  32'(filt),  32'd1);

        // Reset while in the high-check state abandons the debounce
        din = 1'b0;
        step(7);
        check("pre_mid_filt", 32'(filt), 32'd0);
        din = 1'b1;
        step(3);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_filt",  32'(filt),  32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            check("mid_filt", 32'(filt), 32'(i >= 6));
            check("mid_rise", 32'(rise), 32'(i == 6));
        end
        step(1);
        check("mid_count", 32'(count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
